// File: rtl/binary_stream_gen.sv
// Binary pixel-stream source: frame/line timing with programmable blanking and
// pixel pacing, plus a selectable binary test pattern for the morphology chain.
module binary_stream_gen #(
    parameter logic [9:0] IMG_HDISP = 10'd640,
    parameter logic [9:0] IMG_VDISP = 10'd480,
    parameter int         CLK_DIV   = 2,
    parameter int         HB_CLKS   = 160,
    parameter int         VB_CLKS   = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    input  logic [9:0] box_x0,
    input  logic [9:0] box_x1,
    input  logic [9:0] box_y0,
    input  logic [9:0] box_y1,
    output logic       per_frame_vsync,
    output logic       per_frame_href,
    output logic       per_frame_clken,
    output logic       per_img_Bit,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       frame_done,
    output logic       busy
);

    localparam int CNT_MAX = (VB_CLKS > HB_CLKS) ? VB_CLKS : HB_CLKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DIV_W   = $clog2(CLK_DIV + 1);

    localparam logic [CNT_W-1:0] VB_LAST  = CNT_W'(VB_CLKS - 1);
    localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'(HB_CLKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [9:0]       X_LAST   = IMG_HDISP - 10'd1;
    localparam logic [9:0]       Y_LAST   = IMG_VDISP - 10'd1;

    if ((CLK_DIV < 32'sd1) || (HB_CLKS < 32'sd1) || (VB_CLKS < 32'sd1) ||
        (IMG_HDISP == 10'd0) || (IMG_VDISP == 10'd0)) begin : g_param_err
        $error("binary_stream_gen: parameter outside its legal range");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VBLANK = 3'd1,
        S_HBLANK = 3'd2,
        S_ACTIVE = 3'd3,
        S_TAIL   = 3'd4
    } state_t;

    function automatic logic pixel_bit(input logic [1:0] mode,
                                       input logic [9:0] x, input logic [9:0] y,
                                       input logic [9:0] x0, input logic [9:0] x1,
                                       input logic [9:0] y0, input logic [9:0] y1);
        case (mode)
            2'd0:    pixel_bit = 1'b0;
            2'd1:    pixel_bit = 1'b1;
            2'd2:    pixel_bit = (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
            2'd3:    pixel_bit = x[3] ^ y[3];
            default: pixel_bit = 1'b0;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d, y_q, y_d;
    logic [1:0]       mode_q, mode_d;
    logic [9:0]       bx0_q, bx0_d, bx1_q, bx1_d, by0_q, by0_d, by1_q, by1_d;

    logic       vsync_d, href_d, clken_d, bit_d, fdone_d, busy_d;
    logic [9:0] pix_x_d, pix_y_d;

    // Next-state: blanking counters, pixel pacing and frame-constant pattern latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        x_d     = x_q;
        y_d     = y_q;
        mode_d  = mode_q;
        bx0_d   = bx0_q;
        bx1_d   = bx1_q;
        by0_d   = by0_q;
        by1_d   = by1_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                div_d = '0;
                x_d   = 10'd0;
                y_d   = 10'd0;
                if (enable) state_d = S_VBLANK;
                else        state_d = S_IDLE;
            end
            S_VBLANK: begin
                if (cnt_q == VB_LAST) begin
                    state_d = S_HBLANK;
                    cnt_d   = '0;
                    y_d     = 10'd0;
                    mode_d  = pattern_sel;
                    bx0_d   = box_x0;
                    bx1_d   = box_x1;
                    by0_d   = box_y0;
                    by1_d   = box_y1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    state_d = S_ACTIVE;
                    cnt_d   = '0;
                    div_d   = '0;
                    x_d     = 10'd0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_ACTIVE: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (x_q == X_LAST) begin
                        x_d = 10'd0;
                        if (y_q == Y_LAST) begin
                            state_d = S_TAIL;
                            y_d     = 10'd0;
                        end else begin
                            state_d = S_HBLANK;
                            y_d     = y_q + 10'd1;
                        end
                    end else begin
                        x_d = x_q + 10'd1;
                    end
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            S_TAIL: begin
                // enable is only sampled here, so a frame in flight always completes
                if (cnt_q == HB_LAST) begin
                    cnt_d = '0;
                    if (enable) state_d = S_VBLANK;
                    else        state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                div_d   = '0;
                x_d     = 10'd0;
                y_d     = 10'd0;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up with state_q.
    always_comb begin
        vsync_d = (state_d == S_HBLANK) || (state_d == S_ACTIVE) || (state_d == S_TAIL);
        href_d  = (state_d == S_ACTIVE);
        clken_d = href_d && (div_d == '0);
        fdone_d = (state_d == S_TAIL) && (cnt_d == HB_LAST);
        busy_d  = (state_d != S_IDLE);
        if (href_d) begin
            pix_x_d = x_d;
            pix_y_d = y_d;
            bit_d   = pixel_bit(mode_d, x_d, y_d, bx0_d, bx1_d, by0_d, by1_d);
        end else begin
            pix_x_d = 10'd0;
            pix_y_d = 10'd0;
            bit_d   = 1'b0;
        end
    end

    // State, counter and latched-pattern registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            x_q     <= 10'd0;
            y_q     <= 10'd0;
            mode_q  <= 2'd0;
            bx0_q   <= 10'd0;
            bx1_q   <= 10'd0;
            by0_q   <= 10'd0;
            by1_q   <= 10'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mode_q  <= mode_d;
            bx0_q   <= bx0_d;
            bx1_q   <= bx1_d;
            by0_q   <= by0_d;
            by1_q   <= by1_d;
        end
    end

    // Registered stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_frame_vsync <= 1'b0;
            per_frame_href  <= 1'b0;
            per_frame_clken <= 1'b0;
            per_img_Bit     <= 1'b0;
            pix_x           <= 10'd0;
            pix_y           <= 10'd0;
            frame_done      <= 1'b0;
            busy            <= 1'b0;
        end else begin
            per_frame_vsync <= vsync_d;
            per_frame_href  <= href_d;
            per_frame_clken <= clken_d;
            per_img_Bit     <= bit_d;
            pix_x           <= pix_x_d;
            pix_y           <= pix_y_d;
            frame_done      <= fdone_d;
            busy            <= busy_d;
        end
    end

endmodule
